// File: rtl/int_exc_if.sv
// ---------------------------------------------------------------------------
// int_exc_if
// Bundles the signals that run between the pipeline and int_exc_sequencer.
//   master : the pipeline side. It drives stall, int_req, the exception
//            pulses and exc_pc, and it observes the sequencer outputs.
//   slave  : the sequencer side. It receives the pipeline inputs and drives
//            exceptions, interrupts, epc, epc_we, fetch_hold and int_pending.
// ---------------------------------------------------------------------------
interface int_exc_if #(
    parameter int PC_W = 32
);
    logic            stall;        // pipeline freeze
    logic            int_req;      // external interrupt pin, synchronous to clk
    logic            exc_stack;    // stack-empty exception pulse
    logic            exc_mem;      // invalid-address exception pulse
    logic [PC_W-1:0] exc_pc;       // PC of the faulting instruction
    logic [3:0]      exceptions;   // one-hot exception step
    logic [2:0]      interrupts;   // one-hot interrupt step
    logic [PC_W-1:0] epc;          // captured exception PC
    logic            epc_we;       // high in the first exception step
    logic            fetch_hold;   // high while a sequence runs
    logic            int_pending;  // latched, unserviced interrupt

    modport master (
        output stall, int_req, exc_stack, exc_mem, exc_pc,
        input  exceptions, interrupts, epc, epc_we, fetch_hold, int_pending
    );

    modport slave (
        input  stall, int_req, exc_stack, exc_mem, exc_pc,
        output exceptions, interrupts, epc, epc_we, fetch_hold, int_pending
    );
endinterface

// File: rtl/int_exc_sequencer.sv
// ---------------------------------------------------------------------------
// int_exc_sequencer
// Converts the raw exception pulses and the external interrupt pin into the
// timed one-hot step sequences that the control unit decodes. It captures the
// faulting PC into EPC and holds fetch while a sequence runs.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : int_exc_if.slave
//                (inputs : stall, int_req, exc_stack, exc_mem, exc_pc;
//                 outputs: exceptions, interrupts, epc, epc_we, fetch_hold,
//                          int_pending)
// All outputs are registered from the next-state decode, so a step appears
// in the cycle after the edge that chose it.
// ---------------------------------------------------------------------------
module int_exc_sequencer #(
    parameter int PC_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    int_exc_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_EA1, S_EA2, S_EB1, S_EB2, S_I1, S_I2, S_I3
    } state_e;

    state_e          state_q, state_d;
    logic            int_q, int_d;               // int_req edge register
    logic            int_pending_q, int_pending_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [3:0]      exceptions_q, exceptions_d;
    logic [2:0]      interrupts_q, interrupts_d;
    logic            epc_we_q, epc_we_d;
    logic            fetch_hold_q, fetch_hold_d;

    logic            rise;
    logic            exc_any;
    state_e          exc_target;

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this
        // block can infer a latch; the same defaults give the stall hold.
        state_d       = state_q;
        int_d         = int_q;
        int_pending_d = int_pending_q;
        epc_d         = epc_q;
        rise          = 1'b0;
        exc_any       = bus.exc_mem | bus.exc_stack;
        // exc_mem wins when both exception pulses arrive together.
        exc_target    = bus.exc_mem ? S_EB1 : S_EA1;

        if (!bus.stall) begin
            rise          = bus.int_req & ~int_q;
            int_d         = bus.int_req;
            int_pending_d = int_pending_q | rise;

            unique case (state_q)
                S_IDLE: begin
                    if (exc_any) begin
                        state_d = exc_target;
                        epc_d   = bus.exc_pc;
                    end else if (int_pending_q | rise) begin
                        state_d = S_I1;
                    end
                end
                S_EA1: state_d = S_EA2;
                S_EA2: state_d = S_IDLE;
                S_EB1: state_d = S_EB2;
                S_EB2: state_d = S_IDLE;
                // An exception preempts the first two interrupt steps; the
                // pending flag survives, so the interrupt restarts at I1
                // once the exception has completed.
                S_I1, S_I2: begin
                    if (exc_any) begin
                        state_d = exc_target;
                        epc_d   = bus.exc_pc;
                    end else begin
                        state_d = (state_q == S_I1) ? S_I2 : S_I3;
                    end
                end
                // Exceptions are ignored here because the handler is already
                // loading. The interrupt counts as serviced unless a new rise
                // lands on this same edge.
                S_I3: begin
                    state_d       = S_IDLE;
                    int_pending_d = rise;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs decode the next state. Under stall state_d equals state_q,
        // so the outputs hold and the current step repeats.
        exceptions_d = 4'b0000;
        interrupts_d = 3'b000;
        epc_we_d     = 1'b0;
        unique case (state_d)
            S_EA1: begin exceptions_d = 4'b0001; epc_we_d = 1'b1; end
            S_EA2:       exceptions_d = 4'b0100;
            S_EB1: begin exceptions_d = 4'b0010; epc_we_d = 1'b1; end
            S_EB2:       exceptions_d = 4'b1000;
            S_I1:        interrupts_d = 3'b001;
            S_I2:        interrupts_d = 3'b010;
            S_I3:        interrupts_d = 3'b100;
            default:     ;
        endcase
        fetch_hold_d = (state_d != S_IDLE);
    end

    // NOTE: the reset is synchronous, so it sits inside the clocked branch.
    // Non-blocking assignments make every flop sample the values from before
    // the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            int_q         <= 1'b0;
            int_pending_q <= 1'b0;
            epc_q         <= '0;
            exceptions_q  <= 4'b0000;
            interrupts_q  <= 3'b000;
            epc_we_q      <= 1'b0;
            fetch_hold_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_q         <= int_d;
            int_pending_q <= int_pending_d;
            epc_q         <= epc_d;
            exceptions_q  <= exceptions_d;
            interrupts_q  <= interrupts_d;
            epc_we_q      <= epc_we_d;
            fetch_hold_q  <= fetch_hold_d;
        end
    end

    assign bus.exceptions  = exceptions_q;
    assign bus.interrupts  = interrupts_q;
    assign bus.epc         = epc_q;
    assign bus.epc_we      = epc_we_q;
    assign bus.fetch_hold  = fetch_hold_q;
    assign bus.int_pending = int_pending_q;

endmodule

// File: tb/tb_int_exc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_int_exc_sequencer
// Drives directed scenarios and then random traffic into int_exc_sequencer.
// A behavioural model tracks the active sequence as (kind, step index) and
// predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_int_exc_sequencer;

    localparam int PC_W = 32;

    localparam int M_IDLE = 0;
    localparam int M_EA   = 1;
    localparam int M_EB   = 2;
    localparam int M_INT  = 3;

    logic clk;
    logic reset;

    int_exc_if #(.PC_W(PC_W)) bus ();

    int_exc_sequencer #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: the kind of sequence in flight and the step within it.
    int          m_mode;
    int          m_step;
    bit          m_pend;
    bit          m_intq;
    logic [31:0] m_epc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_enter(input bit em, input logic [31:0] pc);
        m_mode = em ? M_EB : M_EA;
        m_step = 0;
        m_epc  = pc;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit ir, input bit es,
                              input bit em, input logic [31:0] pc);
        bit rise;
        bit exc;
        bit new_pend;
        if (r) begin
            m_mode = M_IDLE; m_step = 0; m_pend = 0; m_intq = 0; m_epc = 0;
            return;
        end
        if (s) return;
        rise     = ir && !m_intq;
        m_intq   = ir;
        exc      = es || em;
        new_pend = m_pend || rise;
        if (m_mode == M_IDLE) begin
            if (exc) model_enter(em, pc);
            else if (new_pend) begin m_mode = M_INT; m_step = 0; end
        end else if (m_mode == M_INT) begin
            if (m_step < 2 && exc) model_enter(em, pc);
            else if (m_step == 2) begin m_mode = M_IDLE; new_pend = rise; end
            else m_step++;
        end else begin
            if (m_step == 1) m_mode = M_IDLE;
            else m_step++;
        end
        m_pend = new_pend;
    endtask

    task automatic compare_all();
        logic [31:0] exp_exc;
        logic [31:0] exp_int;
        exp_exc = 0;
        exp_int = 0;
        if (m_mode == M_EA) exp_exc = (m_step == 0) ? 32'd1 : 32'd4;
        if (m_mode == M_EB) exp_exc = (m_step == 0) ? 32'd2 : 32'd8;
        if (m_mode == M_INT) exp_int = 32'd1 << m_step;
        check("exceptions",  {28'd0, bus.exceptions}, exp_exc);
        check("interrupts",  {29'd0, bus.interrupts}, exp_int);
        check("epc",         bus.epc, m_epc);
        check("epc_we",      {31'd0, bus.epc_we},
              {31'd0, (m_mode == M_EA || m_mode == M_EB) && m_step == 0});
        check("fetch_hold",  {31'd0, bus.fetch_hold}, {31'd0, m_mode != M_IDLE});
        check("int_pending", {31'd0, bus.int_pending}, {31'd0, m_pend});
    endtask

    // One clock: drive at the falling edge, let the model see the same
    // inputs, then compare 1 ns after the rising edge.
    task automatic cyc(input bit r, input bit s, input bit ir, input bit es,
                       input bit em, input logic [31:0] pc);
        @(negedge clk);
        reset         = r;
        bus.stall     = s;
        bus.int_req   = ir;
        bus.exc_stack = es;
        bus.exc_mem   = em;
        bus.exc_pc    = pc;
        model_edge(r, s, ir, es, em, pc);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    int          i1_starts;
    logic [2:0]  prev_int;
    bit          r_r, r_s, r_ir, r_es, r_em;

    initial begin
        reset = 1'b1; bus.stall = 0; bus.int_req = 0;
        bus.exc_stack = 0; bus.exc_mem = 0; bus.exc_pc = '0;
        m_mode = M_IDLE; m_step = 0; m_pend = 0; m_intq = 0; m_epc = 0;

        // Reset, then idle.
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            check("idle_hold", {31'd0, bus.fetch_hold}, 32'd0);
        end

        // A level-held int_req produces exactly one sequence.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 0, 32'h0);
            if (i == 0) check("lvl_i1", {29'd0, bus.interrupts}, 32'd1);
            if (i == 1) check("lvl_i2", {29'd0, bus.interrupts}, 32'd2);
            if (i == 2) check("lvl_i3", {29'd0, bus.interrupts}, 32'd4);
            if (i >= 3) begin
                check("lvl_done", {29'd0, bus.interrupts}, 32'd0);
                check("lvl_pend", {31'd0, bus.int_pending}, 32'd0);
            end
        end
        idle(2);

        // Stack exception, then simultaneous mem+stack.
        cyc(0, 0, 0, 1, 0, 32'h40);
        check("ea1", {28'd0, bus.exceptions}, 32'd1);
        check("ea1_epc", bus.epc, 32'h40);
        check("ea1_we", {31'd0, bus.epc_we}, 32'd1);
        idle(1);
        check("ea2", {28'd0, bus.exceptions}, 32'd4);
        check("ea2_we", {31'd0, bus.epc_we}, 32'd0);
        idle(1);
        cyc(0, 0, 0, 1, 1, 32'h88);
        check("eb1", {28'd0, bus.exceptions}, 32'd2);
        check("eb1_epc", bus.epc, 32'h88);
        idle(1);
        check("eb2", {28'd0, bus.exceptions}, 32'd8);
        idle(2);
        check("epc_hold", bus.epc, 32'h88);

        // exc_mem preempts an interrupt in I2; the interrupt restarts after.
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 1, 32'h1C);
        check("pre_eb1", {28'd0, bus.exceptions}, 32'd2);
        check("pre_pend", {31'd0, bus.int_pending}, 32'd1);
        check("pre_epc", bus.epc, 32'h1C);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("pre_eb2", {28'd0, bus.exceptions}, 32'd8);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("pre_restart", {29'd0, bus.interrupts}, 32'd1);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("pre_i3_pend", {31'd0, bus.int_pending}, 32'd1);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("pre_clear", {31'd0, bus.int_pending}, 32'd0);
        idle(2);

        // Stall in I1 repeats the step.
        cyc(0, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 32'h0);
            check("stall_i1", {29'd0, bus.interrupts}, 32'd1);
        end
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("stall_i2", {29'd0, bus.interrupts}, 32'd2);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        idle(1);

        // Rise during an exception is serviced afterwards.
        cyc(0, 0, 0, 1, 0, 32'h20);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("exc_rise_pend", {31'd0, bus.int_pending}, 32'd1);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("exc_rise_i1", {29'd0, bus.interrupts}, 32'd1);
        idle(5);

        // Two pulses around an exception sequence -> exactly one interrupt sequence.
        i1_starts = 0;
        prev_int  = 3'b000;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 0, (i == 1 || i == 3), 0, (i == 0), 32'h30);
            if (bus.interrupts == 3'b001 && prev_int != 3'b001) i1_starts++;
            prev_int = bus.interrupts;
        end
        check("two_pulse_seq", i1_starts, 32'd1);

        // Rise on the I3->IDLE edge keeps int_pending and starts another sequence.
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("i3_edge_pend", {31'd0, bus.int_pending}, 32'd1);
        check("i3_edge_idle", {31'd0, bus.fetch_hold}, 32'd0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        check("i3_edge_next", {29'd0, bus.interrupts}, 32'd1);
        cyc(0, 0, 0, 0, 0, 32'h0);
        idle(4);

        // Reset while in I2 aborts and discards the pending interrupt.
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("rst_at_i2", {29'd0, bus.interrupts}, 32'd2);
        cyc(1, 0, 0, 0, 0, 32'h0);
        check("rst_int", {29'd0, bus.interrupts}, 32'd0);
        check("rst_pend", {31'd0, bus.int_pending}, 32'd0);
        idle(2);

        // Random traffic against the model.
        r_ir = 0;
        for (int i = 0; i < 3000; i++) begin
            r_r  = ($urandom_range(0, 199) == 0);
            r_s  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) r_ir = ~r_ir;
            r_es = ($urandom_range(0, 9) == 0);
            r_em = ($urandom_range(0, 11) == 0);
            cyc(r_r, r_s, r_ir, r_es, r_em, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
